// File: rtl/can_cpu_regif.sv
// CAN controller register target: config registers, TX/RX word FIFOs, interrupt.
// Responds one cycle after cs is sampled; a held cs is parked in REL until released.
module can_cpu_regif #(
  parameter int TXF_AW = 4,
  parameter int RXF_AW = 4
) (
  input  logic        sysclk,
  input  logic        ponrst_n,
  input  logic        cpu_cs,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdat,
  output logic [31:0] cpu_rdat,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cfg_brp,
  output logic [31:0] cfg_btn,
  output logic [31:0] cfg_btd,
  output logic [31:0] cfg_ie,
  output logic [31:0] cfg_rb,
  output logic [31:0] cfg_tb,
  output logic [31:0] cfg_thb,
  output logic [31:0] cfg_af1,
  output logic [31:0] cfg_af2,
  output logic        cmd_start,
  input  logic        tx_rd,
  output logic [31:0] tx_dout,
  output logic        tx_empty,
  input  logic        rx_wr,
  input  logic [31:0] rx_din,
  output logic        rx_full,
  output logic        int_o
);

  localparam int TXD = 1 << TXF_AW;
  localparam int RXD = 1 << RXF_AW;

  localparam logic [31:0] A_STATUS = 32'h000;
  localparam logic [31:0] A_CMD    = 32'h004;
  localparam logic [31:0] A_BRP    = 32'h008;
  localparam logic [31:0] A_BTN    = 32'h00C;
  localparam logic [31:0] A_BTD    = 32'h010;
  localparam logic [31:0] A_IE     = 32'h024;
  localparam logic [31:0] A_RB     = 32'h040;
  localparam logic [31:0] A_TB     = 32'h044;
  localparam logic [31:0] A_THB    = 32'h048;
  localparam logic [31:0] A_AF1    = 32'h100;
  localparam logic [31:0] A_AF2    = 32'h104;
  localparam logic [31:0] A_RXD    = 32'h200;
  localparam logic [31:0] A_TXD    = 32'h204;

  typedef enum logic [1:0] {IDLE, RESP, REL} state_t;
  state_t state;

  logic [31:0]       tx_mem [TXD];
  logic [TXF_AW-1:0] tx_wp, tx_rp;
  logic [TXF_AW:0]   tx_cnt;
  logic [31:0]       rx_mem [RXD];
  logic [RXF_AW-1:0] rx_wp, rx_rp;
  logic [RXF_AW:0]   rx_cnt;
  logic              rx_ovf;
  logic              tx_full, rx_empty;

  assign tx_full  = (tx_cnt == (TXF_AW+1)'(TXD));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == (RXF_AW+1)'(RXD));
  assign rx_empty = (rx_cnt == '0);
  assign tx_dout  = tx_mem[tx_rp];

  // Address decode and legality check; only meaningful while IDLE with cs high.
  logic        hit, rd_ok, wr_ok, acc_err;
  logic [31:0] rd_val;
  always_comb begin
    hit    = 1'b1;
    rd_ok  = 1'b1;
    wr_ok  = 1'b1;
    rd_val = '0;
    case (cpu_addr)
      A_STATUS: begin
        wr_ok  = 1'b0;
        rd_val = {13'b0, rx_ovf, rx_empty, tx_full, 8'(rx_cnt), 8'(tx_cnt)};
      end
      A_CMD:    rd_val = '0;
      A_BRP:    rd_val = cfg_brp;
      A_BTN:    rd_val = cfg_btn;
      A_BTD:    rd_val = cfg_btd;
      A_IE:     rd_val = cfg_ie;
      A_RB:     rd_val = cfg_rb;
      A_TB:     rd_val = cfg_tb;
      A_THB:    rd_val = cfg_thb;
      A_AF1:    rd_val = cfg_af1;
      A_AF2:    rd_val = cfg_af2;
      A_RXD: begin
        wr_ok  = 1'b0;
        rd_ok  = !rx_empty;
        rd_val = rx_empty ? 32'h0 : rx_mem[rx_rp];
      end
      A_TXD: begin
        rd_ok = 1'b0;
        wr_ok = !tx_full;
      end
      default:  hit = 1'b0;
    endcase
    acc_err = (cpu_read == cpu_write) || (cpu_addr[1:0] != 2'b00) || !hit ||
              (cpu_read && !rd_ok) || (cpu_write && !wr_ok);
  end

  logic accept, do_wr, do_rd;
  assign accept = (state == IDLE) && cpu_cs && !acc_err;
  assign do_wr  = accept && cpu_write;
  assign do_rd  = accept && cpu_read;

  logic wr_cmd, tx_flush, rx_flush, ovf_clr;
  logic tx_push, tx_pop, rx_push, rx_pop, ovf_set;
  assign wr_cmd   = do_wr && (cpu_addr == A_CMD);
  assign tx_flush = wr_cmd && cpu_wdat[1];
  assign rx_flush = wr_cmd && cpu_wdat[2];
  assign ovf_clr  = wr_cmd && cpu_wdat[3];
  assign tx_push  = do_wr && (cpu_addr == A_TXD);
  assign tx_pop   = tx_rd && !tx_empty && !tx_flush;
  assign rx_pop   = do_rd && (cpu_addr == A_RXD);
  // A pop in the same cycle frees the slot, so a push to a full RX FIFO is still taken.
  assign rx_push  = rx_wr && !rx_flush && (!rx_full || rx_pop);
  assign ovf_set  = rx_wr && !rx_flush && rx_full && !rx_pop;

  always_ff @(posedge sysclk or negedge ponrst_n) begin
    if (!ponrst_n) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdat  <= '0;
      cmd_start <= 1'b0;
    end else begin
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdat  <= '0;
      cmd_start <= 1'b0;
      case (state)
        IDLE: if (cpu_cs) begin
          state     <= RESP;
          cpu_ack   <= !acc_err;
          cpu_err   <= acc_err;
          cpu_rdat  <= do_rd ? rd_val : 32'h0;
          cmd_start <= wr_cmd && cpu_wdat[0];
        end
        RESP:    state <= REL;
        REL:     if (!cpu_cs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge ponrst_n) begin
    if (!ponrst_n) begin
      cfg_brp <= '0; cfg_btn <= '0; cfg_btd <= '0;
      cfg_ie  <= '0; cfg_rb  <= '0; cfg_tb  <= '0;
      cfg_thb <= '0; cfg_af1 <= '0; cfg_af2 <= '0;
    end else if (do_wr) begin
      case (cpu_addr)
        A_BRP:   cfg_brp <= cpu_wdat;
        A_BTN:   cfg_btn <= cpu_wdat;
        A_BTD:   cfg_btd <= cpu_wdat;
        A_IE:    cfg_ie  <= cpu_wdat;
        A_RB:    cfg_rb  <= cpu_wdat;
        A_TB:    cfg_tb  <= cpu_wdat;
        A_THB:   cfg_thb <= cpu_wdat;
        A_AF1:   cfg_af1 <= cpu_wdat;
        A_AF2:   cfg_af2 <= cpu_wdat;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (tx_push) tx_mem[tx_wp] <= cpu_wdat;
    if (rx_push) rx_mem[rx_wp] <= rx_din;
  end

  always_ff @(posedge sysclk or negedge ponrst_n) begin
    if (!ponrst_n) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
      rx_ovf <= 1'b0;
      int_o  <= 1'b0;
    end else begin
      if (tx_flush) begin
        tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + TXF_AW'(1);
        if (tx_pop)  tx_rp <= tx_rp + TXF_AW'(1);
        case ({tx_push, tx_pop})
          2'b10:   tx_cnt <= tx_cnt + (TXF_AW+1)'(1);
          2'b01:   tx_cnt <= tx_cnt - (TXF_AW+1)'(1);
          default: ;
        endcase
      end
      if (rx_flush) begin
        rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
      end else begin
        if (rx_push) rx_wp <= rx_wp + RXF_AW'(1);
        if (rx_pop)  rx_rp <= rx_rp + RXF_AW'(1);
        case ({rx_push, rx_pop})
          2'b10:   rx_cnt <= rx_cnt + (RXF_AW+1)'(1);
          2'b01:   rx_cnt <= rx_cnt - (RXF_AW+1)'(1);
          default: ;
        endcase
      end
      if (ovf_set)      rx_ovf <= 1'b1;
      else if (ovf_clr) rx_ovf <= 1'b0;
      int_o <= (cfg_ie[0] && !rx_empty) || (cfg_ie[1] && tx_empty) || (cfg_ie[2] && rx_ovf);
    end
  end

endmodule

// File: tb/tb_can_cpu_regif.sv
// Directed self-checking bench for can_cpu_regif.
module tb_can_cpu_regif;
  logic        sysclk = 1'b0;
  logic        ponrst_n;
  logic        cpu_cs, cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdat, cpu_rdat;
  logic        cpu_ack, cpu_err;
  logic [31:0] cfg_brp, cfg_btn, cfg_btd, cfg_ie, cfg_rb, cfg_tb, cfg_thb, cfg_af1, cfg_af2;
  logic        cmd_start, tx_rd, tx_empty, rx_wr, rx_full, int_o;
  logic [31:0] tx_dout, rx_din;

  int tests = 0;
  int fails = 0;
  logic [31:0] brp_at_resp;

  always #5 sysclk = ~sysclk;

  can_cpu_regif #(.TXF_AW(4), .RXF_AW(4)) dut (
    .sysclk(sysclk), .ponrst_n(ponrst_n),
    .cpu_cs(cpu_cs), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdat(cpu_wdat), .cpu_rdat(cpu_rdat),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cfg_brp(cfg_brp), .cfg_btn(cfg_btn), .cfg_btd(cfg_btd), .cfg_ie(cfg_ie),
    .cfg_rb(cfg_rb), .cfg_tb(cfg_tb), .cfg_thb(cfg_thb), .cfg_af1(cfg_af1), .cfg_af2(cfg_af2),
    .cmd_start(cmd_start), .tx_rd(tx_rd), .tx_dout(tx_dout), .tx_empty(tx_empty),
    .rx_wr(rx_wr), .rx_din(rx_din), .rx_full(rx_full), .int_o(int_o)
  );

  // One bus transaction; returns the response and cycles from cs assertion to it (0 = timeout).
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdat, output logic ack, output logic err,
                      output logic [31:0] rdat, output int lat);
    bit done = 0;
    ack = 0; err = 0; rdat = '0; lat = 0;
    cpu_cs = 1; cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdat = wdat;
    for (int i = 1; i <= 8 && !done; i++) begin
      @(posedge sysclk); #1;
      if (cpu_ack || cpu_err) begin
        ack = cpu_ack; err = cpu_err; rdat = cpu_rdat; lat = i;
        brp_at_resp = cfg_brp;
        done = 1;
      end
    end
    cpu_cs = 0; cpu_read = 0; cpu_write = 0;
    repeat (2) @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset;
    ponrst_n = 0; cpu_cs = 0; cpu_read = 0; cpu_write = 0; cpu_addr = '0; cpu_wdat = '0;
    tx_rd = 0; rx_wr = 0; rx_din = '0;
    repeat (3) @(posedge sysclk);
    #1;
    tests++;
    if ({cpu_ack, cpu_err, cmd_start, int_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000", {cpu_ack, cpu_err, cmd_start, int_o});
    end
    tests++;
    if ((cpu_rdat | cfg_brp | cfg_ie | cfg_af2 | cfg_thb) !== 32'h0) begin
      fails++; $display("FAIL reset_regs: got nonzero rdat/cfg %h", cpu_rdat | cfg_brp | cfg_ie | cfg_af2 | cfg_thb);
    end
    tests++;
    if ({tx_empty, rx_full} !== 2'b10) begin
      fails++; $display("FAIL reset_fifo: got %b want 10", {tx_empty, rx_full});
    end
    ponrst_n = 1;
    @(posedge sysclk); #1;
  endtask

  task automatic test_cfg;
    logic a, e; logic [31:0] r; int lat, acks;
    xfer(0, 1, 32'h008, 32'h0000_000A, a, e, r, lat);
    tests++;
    if ({a, e} !== 2'b10 || lat != 1) begin
      fails++; $display("FAIL brp_write: ack/err %b lat %0d want 10 lat 1", {a, e}, lat);
    end
    tests++;
    if (brp_at_resp !== 32'h0000_000A) begin
      fails++; $display("FAIL brp_in_resp: got %h want 0000000a", brp_at_resp);
    end
    xfer(1, 0, 32'h008, 32'h0, a, e, r, lat);
    tests++;
    if ({a, e} !== 2'b10 || r !== 32'h0000_000A) begin
      fails++; $display("FAIL brp_read: ack/err %b rdat %h want 10 0000000a", {a, e}, r);
    end
    acks = 0;
    cpu_cs = 1; cpu_read = 1; cpu_write = 0; cpu_addr = 32'h008;
    repeat (5) begin
      @(posedge sysclk); #1;
      if (cpu_ack) acks++;
    end
    cpu_cs = 0; cpu_read = 0;
    repeat (3) begin
      @(posedge sysclk); #1;
      if (cpu_ack) acks++;
    end
    tests++;
    if (acks != 1) begin
      fails++; $display("FAIL held_cs: got %0d acks want 1", acks);
    end
  endtask

  task automatic test_tx;
    logic a, e; logic [31:0] r; int lat, bad;
    logic [31:0] words [4];
    words[0] = 32'h1554_0000; words[1] = 32'h0000_0008;
    words[2] = 32'h7C01_A579; words[3] = 32'h8888_8888;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1, 32'h204, words[i], a, e, r, lat);
      if (a !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL tx_push4: got %0d rejected pushes want 0", bad);
    end
    xfer(1, 0, 32'h000, 32'h0, a, e, r, lat);
    tests++;
    if (r !== 32'h0002_0004) begin
      fails++; $display("FAIL tx_status4: got %h want 00020004", r);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (tx_dout !== words[i]) begin
        fails++; $display("FAIL tx_pop%0d: got %h want %h", i, tx_dout, words[i]);
      end
      tx_rd = 1;
      @(posedge sysclk); #1;
      tx_rd = 0;
    end
    tests++;
    if (tx_empty !== 1'b1) begin
      fails++; $display("FAIL tx_empty_after: got %b want 1", tx_empty);
    end
  endtask

  task automatic test_tx_full;
    logic a, e; logic [31:0] r; int lat, bad;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1, 32'h204, 32'h100 + i, a, e, r, lat);
      if (a !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL tx_push16: got %0d rejected want 0", bad);
    end
    xfer(0, 1, 32'h204, 32'hDEAD_BEEF, a, e, r, lat);
    tests++;
    if ({a, e} !== 2'b01) begin
      fails++; $display("FAIL tx_push17: ack/err %b want 01", {a, e});
    end
    xfer(1, 0, 32'h000, 32'h0, a, e, r, lat);
    tests++;
    if (r !== 32'h0003_0010) begin
      fails++; $display("FAIL tx_status16: got %h want 00030010", r);
    end
    xfer(0, 1, 32'h004, 32'h2, a, e, r, lat);
    for (int i = 0; i < 8; i++) xfer(0, 1, 32'h204, 32'h200 + i, a, e, r, lat);
    cpu_cs = 1; cpu_read = 0; cpu_write = 1; cpu_addr = 32'h204; cpu_wdat = 32'h55;
    tx_rd = 1;
    @(posedge sysclk); #1;
    tx_rd = 0;
    a = cpu_ack;
    cpu_cs = 0; cpu_write = 0;
    repeat (2) @(posedge sysclk);
    #1;
    xfer(1, 0, 32'h000, 32'h0, a, e, r, lat);
    tests++;
    if (r !== 32'h0002_0008) begin
      fails++; $display("FAIL tx_push_pop: got status %h want 00020008", r);
    end
  endtask

  task automatic test_rx;
    logic a, e; logic [31:0] r; int lat, bad;
    xfer(1, 0, 32'h200, 32'h0, a, e, r, lat);
    tests++;
    if ({a, e} !== 2'b01 || r !== 32'h0) begin
      fails++; $display("FAIL rx_pop_empty: ack/err %b rdat %h want 01 0", {a, e}, r);
    end
    rx_din = 32'hA000_0000; rx_wr = 1;
    repeat (17) @(posedge sysclk);
    #1;
    rx_wr = 0;
    xfer(1, 0, 32'h000, 32'h0, a, e, r, lat);
    tests++;
    if (rx_full !== 1'b1 || r !== 32'h0004_1008) begin
      fails++; $display("FAIL rx_overflow: full %b status %h want 1 00041008", rx_full, r);
    end
    xfer(0, 1, 32'h004, 32'h8, a, e, r, lat);
    xfer(1, 0, 32'h000, 32'h0, a, e, r, lat);
    tests++;
    if (r !== 32'h0000_1008) begin
      fails++; $display("FAIL rx_ovf_clear: got %h want 00001008", r);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      xfer(1, 0, 32'h200, 32'h0, a, e, r, lat);
      if (a !== 1'b1 || r !== 32'hA000_0000) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL rx_pop16: got %0d bad reads want 0", bad);
    end
    xfer(1, 0, 32'h000, 32'h0, a, e, r, lat);
    tests++;
    if (r !== 32'h0002_0008) begin
      fails++; $display("FAIL rx_drained: got %h want 00020008", r);
    end
  endtask

  task automatic test_errors;
    logic a, e; logic [31:0] r; int lat, bad;
    logic [31:0] eaddr [5];
    logic        erd [5];
    logic        ewr [5];
    eaddr[0] = 32'h300; erd[0] = 1; ewr[0] = 0;
    eaddr[1] = 32'h00A; erd[1] = 1; ewr[1] = 0;
    eaddr[2] = 32'h000; erd[2] = 0; ewr[2] = 1;
    eaddr[3] = 32'h008; erd[3] = 1; ewr[3] = 1;
    eaddr[4] = 32'h204; erd[4] = 1; ewr[4] = 0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      xfer(erd[i], ewr[i], eaddr[i], 32'hFFFF_FFFF, a, e, r, lat);
      if ({a, e} !== 2'b01 || lat != 1) begin
        bad++; $display("FAIL err_case%0d: ack/err %b lat %0d want 01 lat 1", i, {a, e}, lat);
      end
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (cfg_brp !== 32'h0000_000A) begin
      fails++; $display("FAIL err_no_effect: brp %h want 0000000a", cfg_brp);
    end
    xfer(1, 0, 32'h004, 32'h0, a, e, r, lat);
    tests++;
    if ({a, e} !== 2'b10 || r !== 32'h0) begin
      fails++; $display("FAIL cmd_read: ack/err %b rdat %h want 10 0", {a, e}, r);
    end
  endtask

  task automatic test_int;
    logic a, e; logic [31:0] r; int lat;
    xfer(0, 1, 32'h024, 32'h1, a, e, r, lat);
    tests++;
    if (int_o !== 1'b0) begin
      fails++; $display("FAIL int_idle: got %b want 0", int_o);
    end
    rx_din = 32'h1234_5678; rx_wr = 1;
    @(posedge sysclk); #1;
    rx_wr = 0;
    tests++;
    if (int_o !== 1'b0) begin
      fails++; $display("FAIL int_lag: got %b want 0", int_o);
    end
    @(posedge sysclk); #1;
    tests++;
    if (int_o !== 1'b1) begin
      fails++; $display("FAIL int_set: got %b want 1", int_o);
    end
  endtask

  task automatic test_reset_mid;
    logic a, e; logic [31:0] r; int lat, acks;
    cpu_cs = 1; cpu_read = 0; cpu_write = 1; cpu_addr = 32'h024; cpu_wdat = 32'h7;
    @(posedge sysclk); #1;
    tests++;
    if (cpu_ack !== 1'b1) begin
      fails++; $display("FAIL mid_resp: ack %b want 1", cpu_ack);
    end
    ponrst_n = 0;
    #1;
    tests++;
    if (cpu_ack !== 1'b0 || cfg_ie !== 32'h0 || int_o !== 1'b0) begin
      fails++; $display("FAIL mid_reset: ack %b ie %h int %b want 0 0 0", cpu_ack, cfg_ie, int_o);
    end
    cpu_cs = 0; cpu_write = 0;
    @(posedge sysclk); #1;
    ponrst_n = 1;
    acks = 0;
    repeat (3) begin
      @(posedge sysclk); #1;
      if (cpu_ack || cpu_err) acks++;
    end
    tests++;
    if (acks != 0) begin
      fails++; $display("FAIL mid_no_resp: got %0d responses want 0", acks);
    end
    xfer(1, 0, 32'h008, 32'h0, a, e, r, lat);
    tests++;
    if ({a, e} !== 2'b10 || r !== 32'h0 || lat != 1) begin
      fails++; $display("FAIL post_reset_read: ack/err %b rdat %h lat %0d want 10 0 1", {a, e}, r, lat);
    end
  endtask

  initial begin
    test_reset;
    test_cfg;
    test_tx;
    test_tx_full;
    test_rx;
    test_errors;
    test_int;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
